// File: rtl/apb_uart_ctrl_pkg.sv
// Shared constants, types and helpers for the APB UART front-end: 16550 register map,
// init sequence values and the controller state encoding.
package apb_uart_ctrl_pkg;

  localparam logic [7:0] REG_THR_DLL = 8'h00;
  localparam logic [7:0] REG_IER_DLM = 8'h04;
  localparam logic [7:0] REG_FCR     = 8'h08;
  localparam logic [7:0] REG_LCR     = 8'h0C;

  localparam logic [7:0] IER_OFF  = 8'h00;
  localparam logic [7:0] LCR_DLAB = 8'h80;
  localparam logic [7:0] LCR_8N1  = 8'h03;
  localparam logic [7:0] FCR_INIT = 8'hC7;

  localparam int unsigned INIT_LEN = 6;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_op_t;

  typedef enum logic [2:0] {
    ST_INIT_SETUP,
    ST_INIT_ACCESS,
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Rounded-to-nearest 16x oversampling divisor.
  function automatic logic [15:0] uart_divisor(input int unsigned clk, input int unsigned baud);
    int unsigned d;
    d = (clk + 8 * baud) / (16 * baud);
    return d[15:0];
  endfunction

endpackage

// File: rtl/apb_uart_ctrl_arb.sv
// Round-robin request picker: first asserted request at or after ptr, wrapping.
module apb_uart_ctrl_arb #(
  parameter int unsigned NrReq = 2,
  parameter int          IdxW  = 1
) (
  input  logic [NrReq-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic             gnt_vld,
  output logic [IdxW-1:0]  gnt_idx
);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < int'(NrReq); k++) begin
      int j;
      logic [IdxW-1:0] idx;
      j = int'(ptr) + k;
      if (j >= int'(NrReq)) j = j - int'(NrReq);
      idx = IdxW'(j);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/apb_uart_ctrl.sv
// Programs the 16550 after reset, then shares its APB port between NrReq requesters
// with round-robin arbitration; one transfer in flight at a time.
module apb_uart_ctrl
  import apb_uart_ctrl_pkg::*;
#(
  parameter int unsigned NrReq     = 2,
  parameter int unsigned ClkFreqHz = 50_000_000,
  parameter int unsigned BaudRate  = 115_200,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NrReq-1:0]                  req_psel_i,
  input  logic [NrReq-1:0]                  req_penable_i,
  input  logic [NrReq-1:0]                  req_pwrite_i,
  input  logic [NrReq-1:0][AddrWidth-1:0]   req_paddr_i,
  input  logic [NrReq-1:0][DataWidth-1:0]   req_pwdata_i,
  output logic [NrReq-1:0][DataWidth-1:0]   req_prdata_o,
  output logic [NrReq-1:0]                  req_pready_o,
  output logic [NrReq-1:0]                  req_pslverr_o,
  output logic                              uart_psel_o,
  output logic                              uart_penable_o,
  output logic                              uart_pwrite_o,
  output logic [AddrWidth-1:0]              uart_paddr_o,
  output logic [DataWidth-1:0]              uart_pwdata_o,
  input  logic [DataWidth-1:0]              uart_prdata_i,
  input  logic                              uart_pready_i,
  input  logic                              uart_pslverr_i,
  output logic                              init_done_o
);

  localparam int          IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam logic [15:0] DIV  = uart_divisor(ClkFreqHz, BaudRate);

  state_e                 state_q, state_d;
  logic [2:0]             init_idx_q;
  logic [IdxW-1:0]        rr_ptr_q, grant_q, gnt_idx;
  logic                   gnt_vld, wr_q, err_q, init_done_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q, rdata_q;
  init_op_t               rom_op;
  logic                   init_last;

  // PENABLE from requesters carries no information here; transfers key off PSEL.
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  always_comb begin
    case (init_idx_q)
      3'd0:    rom_op = '{REG_IER_DLM, IER_OFF};
      3'd1:    rom_op = '{REG_LCR, LCR_DLAB};
      3'd2:    rom_op = '{REG_THR_DLL, DIV[7:0]};
      3'd3:    rom_op = '{REG_IER_DLM, DIV[15:8]};
      3'd4:    rom_op = '{REG_LCR, LCR_8N1};
      default: rom_op = '{REG_FCR, FCR_INIT};
    endcase
  end

  assign init_last = (init_idx_q == 3'(INIT_LEN - 1));

  apb_uart_ctrl_arb #(.NrReq(NrReq), .IdxW(IdxW)) i_arb (
    .req     (req_psel_i),
    .ptr     (rr_ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT_SETUP;
      init_idx_q  <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_INIT_ACCESS: if (uart_pready_i) begin
          if (init_last) init_done_q <= 1'b1;
          else           init_idx_q  <= init_idx_q + 3'd1;
        end
        ST_IDLE: if (gnt_vld) begin
          grant_q <= gnt_idx;
          wr_q    <= req_pwrite_i[gnt_idx];
          addr_q  <= req_paddr_i[gnt_idx];
          wdata_q <= req_pwdata_i[gnt_idx];
        end
        ST_ACCESS: if (uart_pready_i) begin
          rdata_q <= uart_prdata_i;
          err_q   <= uart_pslverr_i;
        end
        ST_RESP: rr_ptr_q <= (grant_q == IdxW'(NrReq - 1)) ? '0 : grant_q + IdxW'(1);
        default: ;
      endcase
    end
  end

  // Outputs are also gated by rst_ni so they drop the moment reset asserts,
  // not at the next edge.
  always_comb begin
    state_d        = state_q;
    uart_psel_o    = 1'b0;
    uart_penable_o = 1'b0;
    uart_pwrite_o  = 1'b0;
    uart_paddr_o   = '0;
    uart_pwdata_o  = '0;
    req_pready_o   = '0;
    req_prdata_o   = '0;
    req_pslverr_o  = '0;
    if (rst_ni) begin
      case (state_q)
        ST_INIT_SETUP, ST_INIT_ACCESS: begin
          uart_psel_o    = 1'b1;
          uart_penable_o = (state_q == ST_INIT_ACCESS);
          uart_pwrite_o  = 1'b1;
          uart_paddr_o   = AddrWidth'(rom_op.addr);
          uart_pwdata_o  = DataWidth'(rom_op.data);
          if (state_q == ST_INIT_SETUP) state_d = ST_INIT_ACCESS;
          else if (uart_pready_i)       state_d = init_last ? ST_IDLE : ST_INIT_SETUP;
        end
        ST_IDLE: if (gnt_vld) state_d = ST_SETUP;
        ST_SETUP, ST_ACCESS: begin
          uart_psel_o    = 1'b1;
          uart_penable_o = (state_q == ST_ACCESS);
          uart_pwrite_o  = wr_q;
          uart_paddr_o   = addr_q;
          uart_pwdata_o  = wdata_q;
          if (state_q == ST_SETUP) state_d = ST_ACCESS;
          else if (uart_pready_i)  state_d = ST_RESP;
        end
        ST_RESP: begin
          req_pready_o[grant_q]  = 1'b1;
          req_prdata_o[grant_q]  = rdata_q;
          req_pslverr_o[grant_q] = err_q;
          state_d                = ST_IDLE;
        end
        default: state_d = ST_INIT_SETUP;
      endcase
    end
  end

  assign init_done_o = init_done_q;

endmodule
